ins_fetch: RTL and testbench
============================

Name: ins_fetch

Overview:
Instruction source for the uProcessor core. It drives the 6-bit instruction bus that the instruction decoder consumes.
- Holds a small program memory, loaded word-by-word over a valid/ready load port.
- On Start, issues the stored program one instruction per cycle with a program counter, then parks on NOP and flags Done.

Parameters:
DEPTH, 16, program memory depth in instructions (power of 2, >=2)
AW, $clog2(DEPTH), program counter / write pointer width (derived, not overridden)

Ports:
CLK  in  1  clock
nRST  in  1  reset (async, active-low)
LoadStart  in  1  pulse: begin loading a new program
LoadValid  in  1  LoadData valid
LoadLast  in  1  marks final word of program (qualified by LoadValid)
LoadData  in  6  instruction word to store
LoadReady  out  1  block accepts load words
Start  in  1  pulse: run stored program from PC=0
Ins  out  6  instruction to decoder, {opcode[3:0], reg[1:0]}
InsValid  out  1  Ins carries a program instruction this cycle
PC  out  AW  address of the next instruction to issue
Busy  out  1  state is LOAD or RUN
Done  out  1  state is DONE

Behaviour:
- Clock and reset: one clock CLK. nRST is asynchronous and active-low.
- Reset values: state=IDLE, PC=0, write pointer=0, ProgLen=0, Ins=INS_NOP, InsValid=0, LoadReady=0, Busy=0, Done=0.
- Memory contents are not reset. Reset clears ProgLen, so a reload is needed after any reset, including a reset in the middle of LOAD or RUN.
- ProgLen width is AW+1 so that it can hold DEPTH.
- LoadReady, Busy and Done are decodes of the state register. Ins, InsValid and PC are registered.
- IDLE:
  - LoadStart -> LOAD; write pointer=0, ProgLen=0.
  - Else Start with ProgLen>0 -> RUN; PC=0.
  - Else Start with ProgLen=0 -> DONE.
  - LoadStart and Start in the same cycle: LoadStart wins.
- LOAD:
  - LoadReady=1. A word is accepted on every edge with LoadValid=1: mem[wp]<=LoadData, wp++, ProgLen<=wp+1.
  - An accept with LoadLast=1 -> IDLE.
  - Accepting the word at wp==DEPTH-1 -> IDLE, regardless of LoadLast.
  - Cycles with LoadValid=0 hold state. Start and LoadStart are ignored.
- RUN, each edge:
  - Ins<=mem[PC], InsValid<=1, PC<=PC+1 (wraps modulo DEPTH).
  - When PC==ProgLen-1 -> DONE.
  - Start and LoadStart are ignored.
- DONE:
  - Each edge: Ins<=INS_NOP, InsValid<=0.
  - Start -> RUN with PC=0 (re-run the same program). LoadStart -> LOAD. LoadStart has priority.
- Latency: Start sampled at edge k -> mem[0] on Ins after edge k+1; mem[i] after edge k+1+i.
  - Done=1 after edge k+ProgLen, the same cycle the last instruction is on Ins.
  - InsValid=0 after edge k+ProgLen+1.

Optional Feature:
- Macro: INS_FETCH_SINGLE_STEP_EN.
- Defined: adds input Step (1 bit).
  - In RUN, an instruction is issued and PC advances only on edges with Step=1.
  - On other edges Ins is held and InsValid<=0, so InsValid pulses once per step.
  - The DONE transition occurs on the step that issues the last instruction.
- Undefined: no Step port; issue every cycle as above.

Decomposition:
- Package uproc_pkg holds:
  - INS_W=6, OPCODE_W=4, RNUM_W=2
  - OPCODE_NOP=4'b1011 and INS_NOP={OPCODE_NOP,2'b00}
  - enum fetch_state_t {IDLE, LOAD, RUN, DONE}
- Sub-module prog_mem: DEPTH x INS_W, synchronous write, asynchronous read. ins_fetch registers the read data onto Ins.

Test Plan:
- Reset: hold nRST=0 -> Ins=6'b101100, InsValid=0, PC=0, LoadReady/Busy/Done=0. Start after release -> Done=1 next cycle, InsValid never 1.
- Load and run: load 6'h05, 6'h12, 6'h2C (LoadLast on third), then pulse Start at edge k.
  - Ins=05/12/2C after edges k+1..k+3.
  - Done=1 after edge k+3; InsValid=0 and Ins=NOP after edge k+4.
- Load gaps: LoadValid pattern 1,0,0,1,1(last) with data A,x,x,B,C -> stored program exactly A,B,C; ProgLen=3.
- Full depth: 16 words without LoadLast -> LoadReady=0 after the 16th accept and a 17th LoadValid is not written. Run issues all 16, PC wraps to 0, Done=1.
- Priority: LoadStart and Start together in IDLE -> LOAD, LoadReady=1. Start pulses during RUN do not restart PC.
- Reset mid-RUN at PC=2 -> immediate reset values. A following Start goes straight to DONE (ProgLen=0).

Source files
------------

// File: rtl/uproc_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package     : uproc_pkg                                          |
// | Description : Shared instruction-word constants and the fetch    |
// |               state encoding for the uProcessor core.            |
// | Revision    : 1.0  initial release                               |
// +------------------------------------------------------------------+
package uproc_pkg;

  localparam int INS_W    = 6;
  localparam int OPCODE_W = 4;
  localparam int RNUM_W   = 2;

  localparam logic [OPCODE_W-1:0] OPCODE_NOP = 4'b1011;
  localparam logic [INS_W-1:0]    INS_NOP    = {OPCODE_NOP, 2'b00};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } fetch_state_t;

endpackage : uproc_pkg
`default_nettype wire

// File: rtl/prog_mem.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : prog_mem                                           |
// | Description : DEPTH x INS_W program store, synchronous write,    |
// |               asynchronous read. Contents are never reset.       |
// | Revision    : 1.0  initial release                               |
// +------------------------------------------------------------------+
module prog_mem
  import uproc_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [INS_W-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [INS_W-1:0] o_rdata
);

  logic [INS_W-1:0] r_mem [DEPTH];

  // Write port: one word per enabled edge.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule : prog_mem
`default_nettype wire

// File: rtl/ins_fetch.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : ins_fetch                                          |
// | Description : Instruction source for the uProcessor decoder.     |
// |               Loads a program over a valid/ready port, then on   |
// |               Start issues it one instruction per cycle and      |
// |               parks on NOP with Done raised.                     |
// |               Optional macro INS_FETCH_SINGLE_STEP_EN adds a     |
// |               Step input gating each issue in RUN.               |
// | Revision    : 1.0  initial release                               |
// +------------------------------------------------------------------+
module ins_fetch
  import uproc_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             LoadStart,
  input  logic             LoadValid,
  input  logic             LoadLast,
  input  logic [INS_W-1:0] LoadData,
  output logic             LoadReady,
  input  logic             Start,
`ifdef INS_FETCH_SINGLE_STEP_EN
  input  logic             Step,
`endif
  output logic [INS_W-1:0] Ins,
  output logic             InsValid,
  output logic [AW-1:0]    PC,
  output logic             Busy,
  output logic             Done
);

  localparam logic [AW-1:0] c_ptr_one  = AW'(1);
  localparam logic [AW-1:0] c_ptr_last = AW'(DEPTH - 1);
  localparam logic [AW:0]   c_len_one  = (AW + 1)'(1);

  fetch_state_t     r_state;
  fetch_state_t     w_state_next;
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_pc;
  logic [AW:0]      r_prog_len;
  logic [INS_W-1:0] r_ins;
  logic             r_ins_valid;
  logic [INS_W-1:0] w_mem_rdata;
  logic             w_step;
  logic             w_accept;
  logic             w_issue;
  logic             w_load_init;
  logic             w_run_init;
  logic             w_last_pc;
  logic             w_wp_full;

`ifdef INS_FETCH_SINGLE_STEP_EN
  assign w_step = Step;
`else
  assign w_step = 1'b1;
`endif

  assign w_last_pc = ({1'b0, r_pc} == (r_prog_len - c_len_one));
  assign w_wp_full = (r_wp == c_ptr_last);

  prog_mem #(
    .DEPTH (DEPTH)
  ) u_prog_mem (
    .clk     (CLK),
    .i_we    (w_accept),
    .i_waddr (r_wp),
    .i_wdata (LoadData),
    .i_raddr (r_pc),
    .o_rdata (w_mem_rdata)
  );

  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode and datapath strobes; LoadStart outranks Start.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_issue      = 1'b0;
    w_load_init  = 1'b0;
    w_run_init   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (LoadStart) begin
          w_state_next = LOAD;
          w_load_init  = 1'b1;
        end else if (Start) begin
          if (r_prog_len != '0) begin
            w_state_next = RUN;
            w_run_init   = 1'b1;
          end else begin
            w_state_next = DONE;
          end
        end
      end
      LOAD: begin
        if (LoadValid) begin
          w_accept = 1'b1;
          if (LoadLast || w_wp_full) begin
            w_state_next = IDLE;
          end
        end
      end
      RUN: begin
        if (w_step) begin
          w_issue = 1'b1;
          if (w_last_pc) begin
            w_state_next = DONE;
          end
        end
      end
      DONE: begin
        if (LoadStart) begin
          w_state_next = LOAD;
          w_load_init  = 1'b1;
        end else if (Start && (r_prog_len != '0)) begin
          // An empty program (only possible after reset) would never
          // reach its last PC, so re-run is refused until a reload.
          w_state_next = RUN;
          w_run_init   = 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Load pointer, program length, PC and the registered instruction bus.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_wp        <= '0;
      r_prog_len  <= '0;
      r_pc        <= '0;
      r_ins       <= INS_NOP;
      r_ins_valid <= 1'b0;
    end else begin
      if (w_load_init) begin
        r_wp       <= '0;
        r_prog_len <= '0;
      end else if (w_accept) begin
        r_wp       <= r_wp + c_ptr_one;
        r_prog_len <= {1'b0, r_wp} + c_len_one;
      end

      if (w_run_init) begin
        r_pc <= '0;
      end else if (w_issue) begin
        r_pc <= r_pc + c_ptr_one;
      end

      if (w_issue) begin
        r_ins       <= w_mem_rdata;
        r_ins_valid <= 1'b1;
      end else if (r_state == RUN) begin
        // Waiting for a step: keep the last instruction on the bus.
        r_ins_valid <= 1'b0;
      end else begin
        r_ins       <= INS_NOP;
        r_ins_valid <= 1'b0;
      end
    end
  end

  assign LoadReady = (r_state == LOAD);
  assign Busy      = (r_state == LOAD) || (r_state == RUN);
  assign Done      = (r_state == DONE);
  assign Ins       = r_ins;
  assign InsValid  = r_ins_valid;
  assign PC        = r_pc;

endmodule : ins_fetch
`default_nettype wire

// File: tb/tb_ins_fetch.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : tb_ins_fetch                                       |
// | Description : Scoreboard bench for ins_fetch. A program model    |
// |               predicts the issued stream; a monitor compares     |
// |               each valid instruction against it.                 |
// | Revision    : 1.0  initial release                               |
// +------------------------------------------------------------------+
module tb_ins_fetch;
  import uproc_pkg::*;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  typedef struct packed {
    logic [5:0]    ins;
    logic [AW-1:0] pc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_start = 1'b0;
  logic          load_valid = 1'b0;
  logic          load_last = 1'b0;
  logic [5:0]    load_data = '0;
  logic          load_ready;
  logic          start = 1'b0;
  logic          step = 1'b1;
  logic [5:0]    ins;
  logic          ins_valid;
  logic [AW-1:0] pc;
  logic          busy;
  logic          done;

  exp_t       exp_q[$];
  int         n_tests = 0;
  int         n_fail = 0;
  logic [5:0] m_mem[DEPTH];
  int         m_len = 0;
  logic [5:0] prog[DEPTH];
  int         gap[DEPTH];

  ins_fetch #(.DEPTH(DEPTH)) dut (
    .CLK       (clk),
    .nRST      (rst_n),
    .LoadStart (load_start),
    .LoadValid (load_valid),
    .LoadLast  (load_last),
    .LoadData  (load_data),
    .LoadReady (load_ready),
    .Start     (start),
`ifdef INS_FETCH_SINGLE_STEP_EN
    .Step      (step),
`endif
    .Ins       (ins),
    .InsValid  (ins_valid),
    .PC        (pc),
    .Busy      (busy),
    .Done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every valid instruction must match the head of the model stream.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && ins_valid) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_issue: got Ins=%0h PC=%0h with nothing expected", ins, pc);
      end else begin
        e = exp_q.pop_front();
        check("issue_ins", 32'(ins), 32'(e.ins));
        check("issue_pc", 32'(pc), 32'(e.pc));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load prog[0..n-1] with gap[i] idle cycles before word i.
  task automatic load_prog(input int n, input bit use_last, input bit skip_start);
    if (!skip_start) begin
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
    end
    @(negedge clk);
    check("load_ready_in_load", 32'(load_ready), 32'd1);
    check("busy_in_load", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < gap[i]; g++) begin
        load_valid = 1'b0;
        load_data  = 6'($urandom);
        start      = 1'($urandom_range(0, 1));
        load_start = 1'($urandom_range(0, 1));
        tick();
      end
      start      = 1'b0;
      load_start = 1'b0;
      load_valid = 1'b1;
      load_data  = prog[i];
      load_last  = use_last && (i == n - 1);
      tick();
      m_mem[i] = prog[i];
      m_len    = i + 1;
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    @(negedge clk);
    check("load_ready_after_load", 32'(load_ready), 32'd0);
    check("busy_after_load", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Run the stored program; the model predicts every issued word.
  task automatic run_prog(input bit mid_start);
    for (int i = 0; i < m_len; i++) begin
      exp_q.push_back('{ins: m_mem[i], pc: AW'((i + 1) % DEPTH)});
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= m_len; i++) begin
      tick();
      start = mid_start && (i == 2) && (m_len > 3);
    end
    start = 1'b0;
    @(negedge clk);
    check("done_with_last_ins", 32'(done), 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("ins_valid_after_run", 32'(ins_valid), 32'd0);
    check("ins_nop_after_run", 32'(ins), 32'(INS_NOP));
    check("done_held", 32'(done), 32'd1);
    check("stream_drained", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_gaps();
    for (int i = 0; i < DEPTH; i++) gap[i] = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    clear_gaps();

    // Reset values while held in reset.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ins", 32'(ins), 32'h2C);
    check("rst_ins_valid", 32'(ins_valid), 32'd0);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_load_ready", 32'(load_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    run_prog(1'b0);                      // empty program: straight to DONE

    // Directed three-word program.
    prog[0] = 6'h05; prog[1] = 6'h12; prog[2] = 6'h2C;
    load_prog(3, 1'b1, 1'b0);
    run_prog(1'b0);

    // Gapped load: valid pattern 1,0,0,1,1(last).
    prog[0] = 6'h11; prog[1] = 6'h22; prog[2] = 6'h33;
    gap[1] = 2;
    load_prog(3, 1'b1, 1'b0);
    run_prog(1'b0);
    clear_gaps();

    // Full depth without LoadLast, then an extra word that must be dropped.
    for (int i = 0; i < DEPTH; i++) prog[i] = 6'($urandom);
    prog[0] = 6'h15;
    load_prog(DEPTH, 1'b0, 1'b0);
    load_valid = 1'b1;
    load_data  = 6'h3F;
    tick();
    load_valid = 1'b0;
    run_prog(1'b0);
    @(negedge clk);
    check("pc_wrapped", 32'(pc), 32'd0);
    @(posedge clk);
    #1;

    // LoadStart and Start together: load wins. Start during RUN ignored.
    load_start = 1'b1;
    start      = 1'b1;
    tick();
    load_start = 1'b0;
    start      = 1'b0;
    @(negedge clk);
    check("prio_done_clear", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) prog[i] = 6'($urandom);
    load_prog(6, 1'b1, 1'b1);
    run_prog(1'b1);

    // Randomised programs, lengths and load gaps.
    for (int t = 0; t < 8; t++) begin
      int  n;
      bit  last;
      n    = $urandom_range(1, DEPTH);
      last = (n < DEPTH) ? 1'b1 : 1'($urandom_range(0, 1));
      for (int i = 0; i < DEPTH; i++) begin
        prog[i] = 6'($urandom);
        gap[i]  = $urandom_range(0, 2);
      end
      load_prog(n, last, 1'b0);
      run_prog(1'(t % 2));
      if (t % 3 == 0) run_prog(1'b0);    // re-run from DONE
    end
    clear_gaps();

    // Reset in the middle of RUN at PC=2.
    for (int i = 0; i < 6; i++) prog[i] = 6'($urandom);
    load_prog(6, 1'b1, 1'b0);
    for (int i = 0; i < m_len; i++) begin
      exp_q.push_back('{ins: m_mem[i], pc: AW'((i + 1) % DEPTH)});
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (pc == 4'd2) seen = 1'b1;
    end
    check("reached_pc2", 32'(seen), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_ins", 32'(ins), 32'h2C);
    check("midrst_ins_valid", 32'(ins_valid), 32'd0);
    check("midrst_pc", 32'(pc), 32'd0);
    check("midrst_load_ready", 32'(load_ready), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    exp_q.delete();
    m_len = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    run_prog(1'b0);                      // ProgLen cleared: straight to DONE

    check("final_stream_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_ins_fetch
`default_nettype wire
